// File: rtl/region_probe_pkg.sv
// Shared definitions for the region probe and the draw FSMs that feed the shadow framebuffer.
//   - probe FSM state encoding
//   - default screen geometry
//   - background colour (anything else is "occupied")
//   - framebuffer address helper (y*XSCREEN + x)
package region_probe_pkg;

  localparam int unsigned XSCREEN_DEFAULT = 160;
  localparam int unsigned YSCREEN_DEFAULT = 120;

  localparam logic [2:0] BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StScan,
    StDone
  } probe_state_e;

  // Linear pixel address. The 160-wide screen uses shift-and-add (128 + 32).
  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y,
                                           input int unsigned xs);
    logic [14:0] yy;
    logic [14:0] xx;
    yy = {8'd0, y};
    xx = {7'd0, x};
    if (xs == 160) begin
      return (yy << 7) + (yy << 5) + xx;
    end
    return 15'(32'(y) * xs + 32'(x));
  endfunction

endpackage

// File: rtl/region_probe_shadow_fb.sv
// Shadow copy of the VGA framebuffer, XSCREEN*YSCREEN x 3 bits.
// Ports:
//   CLOCK_50, Resetn      clock and synchronous active-low reset (writes blocked while in reset)
//   wr_x/wr_y/wr_colour   snooped plot bus; wr_plot is the write strobe
//   rd_en/rd_x/rd_y       read request; rd_data is valid the cycle after rd_en
// Off-screen writes are dropped rather than aliased onto another pixel.
// A read and write to the same address in one cycle returns the old contents.
module shadow_fb
  import region_probe_pkg::*;
#(
  parameter int unsigned XSCREEN = XSCREEN_DEFAULT,
  parameter int unsigned YSCREEN = YSCREEN_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [2:0] wr_colour,
  input  logic       wr_plot,
  input  logic       rd_en,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic [2:0] rd_data
);

  localparam int unsigned Depth = XSCREEN * YSCREEN;

  logic [2:0]  mem [Depth];
  logic [14:0] wr_addr;
  logic [14:0] rd_addr;
  logic        wr_en;

  assign wr_addr = pix_addr(wr_x, wr_y, XSCREEN);
  assign rd_addr = pix_addr(rd_x, rd_y, XSCREEN);
  assign wr_en   = Resetn && wr_plot && (32'(wr_x) < XSCREEN) && (32'(wr_y) < YSCREEN);

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_colour;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/region_probe.sv
// Region probe: scans an XDIM x YDIM box of the shadow framebuffer for any non-background pixel.
// Ports:
//   CLOCK_50, Resetn            clock, synchronous active-low reset
//   wr_x/wr_y/wr_colour/wr_plot plot bus shared with the VGA adapter
//   req, req_x, req_y           start a probe at top-left (req_x, req_y); taken only in idle
//   busy                        probe in progress
//   done                        one-cycle pulse when hit/hit_colour/oob are valid
//   hit                         non-background pixel found, or region off-screen
//   hit_colour                  first non-background colour in row-major order, else BG
//   oob                         region extends past the screen edge
module region_probe
  import region_probe_pkg::*;
#(
  parameter int unsigned XSCREEN = XSCREEN_DEFAULT,
  parameter int unsigned YSCREEN = YSCREEN_DEFAULT,
  parameter int unsigned XDIM    = 10,
  parameter int unsigned YDIM    = 10,
  parameter logic [2:0]  BG      = BG_COLOUR
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [2:0] wr_colour,
  input  logic       wr_plot,
  input  logic       req,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [2:0] hit_colour,
  output logic       oob
);

  probe_state_e state;
  logic [7:0]   base_x;
  logic [6:0]   base_y;
  logic [7:0]   xc;
  logic [6:0]   yc;
  logic         all_issued;
  logic         rd_valid;  // rd_data holds a pixel issued last cycle
  logic         rd_last;   // ...and it was the final pixel of the box
  logic [2:0]   rd_data;
  logic         issue;
  logic         last_pix;
  logic         x_oob;
  logic         y_oob;

  assign issue    = (state == StScan) && !all_issued;
  assign last_pix = (xc == 8'(XDIM - 1)) && (yc == 7'(YDIM - 1));
  // Widened by one bit so a box hanging off the right/bottom edge cannot wrap to look valid.
  assign x_oob    = ({1'b0, base_x} + 9'(XDIM)) > 9'(XSCREEN);
  assign y_oob    = ({1'b0, base_y} + 8'(YDIM)) > 8'(YSCREEN);

  shadow_fb #(
    .XSCREEN(XSCREEN),
    .YSCREEN(YSCREEN)
  ) u_shadow_fb (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_colour(wr_colour),
    .wr_plot  (wr_plot),
    .rd_en    (issue),
    .rd_x     (base_x + xc),
    .rd_y     (base_y + yc),
    .rd_data  (rd_data)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state      <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit        <= 1'b0;
      hit_colour <= BG;
      oob        <= 1'b0;
      base_x     <= '0;
      base_y     <= '0;
      xc         <= '0;
      yc         <= '0;
      all_issued <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= issue;
      rd_last  <= issue && last_pix;
      unique case (state)
        StIdle: begin
          if (req) begin
            base_x     <= req_x;
            base_y     <= req_y;
            hit        <= 1'b0;
            oob        <= 1'b0;
            hit_colour <= BG;
            busy       <= 1'b1;
            state      <= StCheck;
          end
        end
        StCheck: begin
          if (x_oob || y_oob) begin
            oob   <= 1'b1;
            hit   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end else begin
            xc         <= '0;
            yc         <= '0;
            all_issued <= 1'b0;
            state      <= StScan;
          end
        end
        StScan: begin
          if (rd_valid && (rd_data != BG)) begin
            // Reads still in flight are simply ignored once we leave SCAN.
            hit        <= 1'b1;
            hit_colour <= rd_data;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= StDone;
          end else if (rd_valid && rd_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end else if (issue) begin
            if (last_pix) begin
              all_issued <= 1'b1;
            end else if (xc == 8'(XDIM - 1)) begin
              xc <= '0;
              yc <= yc + 7'd1;
            end else begin
              xc <= xc + 8'd1;
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_region_probe.sv
module tb_region_probe;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn = 1'b0;
  logic [7:0] wr_x = '0;
  logic [6:0] wr_y = '0;
  logic [2:0] wr_colour = '0;
  logic       wr_plot = 1'b0;
  logic       req = 1'b0;
  logic [7:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic       busy;
  logic       done;
  logic       hit;
  logic [2:0] hit_colour;
  logic       oob;

  region_probe dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_colour (wr_colour),
    .wr_plot   (wr_plot),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hit_colour(hit_colour),
    .oob       (oob)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    logic       hit;
    logic [2:0] col;
    logic       oob;
    int         lat;
    int         t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge CLOCK_50) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hit", int'(hit), int'(e.hit));
        check("hit_colour", int'(hit_colour), int'(e.col));
        check("oob", int'(oob), int'(e.oob));
        check("done_latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic plot(input int x, input int y, input logic [2:0] c);
    wr_x = 8'(x); wr_y = 7'(y); wr_colour = c; wr_plot = 1'b1;
    @(negedge CLOCK_50);
    wr_plot = 1'b0;
  endtask

  // Drives req during cycle 0; returns at the negedge of cycle 1 with t0 = cycle-0 count.
  task automatic start_probe(input int x, input int y, input bit expect_done, input logic h,
                             input logic [2:0] c, input logic o, input int lat, output int t0);
    exp_t e;
    req = 1'b1; req_x = 8'(x); req_y = 7'(y);
    t0 = cyc;
    if (expect_done) begin
      e.hit = h; e.col = c; e.oob = o; e.lat = lat; e.t0 = t0;
      exp_q.push_back(e);
    end
    @(negedge CLOCK_50);
    req = 1'b0;
    if (lat > 2) check("busy_cycle1", int'(busy), 1);
  endtask

  // Returns at the negedge after the done cycle (DUT back in idle).
  task automatic wait_done(input int budget, input bit req_at_done);
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        if (req_at_done) req = 1'b1;
        @(negedge CLOCK_50);
        req = 1'b0;
        return;
      end
      @(negedge CLOCK_50);
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 1000 && cyc != target; i++) @(negedge CLOCK_50);
  endtask

  int t0;

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_oob", int'(oob), 0);
    check("rst_hit_colour", int'(hit_colour), 0);
    Resetn = 1'b1;
    @(negedge CLOCK_50);

    // Bring the shadow memory to a known all-background state.
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) plot(x, y, 3'b000);

    // Empty screen: full scan.
    start_probe(0, 0, 1, 1'b0, 3'b000, 1'b0, 103, t0);
    wait_done(150, 0);

    // Off-screen write must not alias onto (40,11).
    plot(200, 10, 3'b111);
    start_probe(35, 6, 1, 1'b0, 3'b000, 1'b0, 103, t0);
    wait_done(150, 0);

    // 10x10 square at (80,60); probe (75,55) first meets it at k=55.
    for (int y = 60; y < 70; y++)
      for (int x = 80; x < 90; x++) plot(x, y, 3'b100);
    start_probe(75, 55, 1, 1'b1, 3'b100, 1'b0, 59, t0);
    wait_done(150, 0);

    // Out-of-bounds regions and the largest in-bounds corner.
    start_probe(151, 0, 1, 1'b1, 3'b000, 1'b1, 2, t0);
    wait_done(10, 0);
    start_probe(0, 111, 1, 1'b1, 3'b000, 1'b1, 2, t0);
    wait_done(10, 0);
    start_probe(150, 110, 1, 1'b0, 3'b000, 1'b0, 103, t0);
    wait_done(150, 0);

    // req during the scan and in the done cycle is ignored: exactly one done.
    start_probe(0, 0, 1, 1'b0, 3'b000, 1'b0, 103, t0);
    wait_until(t0 + 20);
    req = 1'b1; req_x = 8'd80; req_y = 7'd60;
    repeat (3) @(negedge CLOCK_50);
    req = 1'b0;
    wait_done(150, 1);
    repeat (110) @(negedge CLOCK_50);
    check("no_requeue_busy", int'(busy), 0);

    // Reset mid-scan aborts without done; memory survives.
    start_probe(75, 55, 0, 1'b0, 3'b000, 1'b0, 59, t0);
    wait_until(t0 + 40);
    check("busy_mid_scan", int'(busy), 1);
    Resetn = 1'b0;
    @(negedge CLOCK_50);
    Resetn = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_hit", int'(hit), 0);
    check("abort_hit_colour", int'(hit_colour), 0);
    repeat (80) @(negedge CLOCK_50);
    start_probe(75, 55, 1, 1'b1, 3'b100, 1'b0, 59, t0);
    wait_done(150, 0);

    // Pixel (5,5) is k=55, read issued at cycle 57: a write that cycle is not seen.
    start_probe(0, 0, 1, 1'b0, 3'b000, 1'b0, 103, t0);
    wait_until(t0 + 57);
    plot(5, 5, 3'b010);
    wait_done(150, 0);
    plot(5, 5, 3'b000);
    // One cycle earlier it is seen.
    start_probe(0, 0, 1, 1'b1, 3'b010, 1'b0, 59, t0);
    wait_until(t0 + 56);
    plot(5, 5, 3'b010);
    wait_done(150, 0);

    repeat (5) @(negedge CLOCK_50);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
